// File: rtl/serial_half_subtractor_unit_if.sv
// Handshake and operand bundle for the bit-serial subtractor.
// The slave side is the subtractor; the master side is whatever drives it.
interface serial_half_subtractor_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready_in;
    logic             busy;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  start, a, b, out_ready,
        output ready_in, busy, diff, borrow_out, out_valid
    );

    modport master (
        output start, a, b, out_ready,
        input  ready_in, busy, diff, borrow_out, out_valid
    );
endinterface

// File: rtl/serial_half_subtractor_unit.sv
// Bit-serial subtractor: computes A - B one bit per clock, LSB first,
// using an XOR/AND full-subtractor cell plus a borrow flip-flop. The
// result and final borrow are offered under a valid/ready handshake.
//
// state | meaning
// IDLE  | ready_in=1, waiting for start; operands latched on start
// SHIFT | busy=1, one difference bit per clock for WIDTH clocks
// HOLD  | out_valid=1, result held until out_ready
module serial_half_subtractor_unit #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_half_subtractor_unit_if.slave sub
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic x_bit, y_bit, b_in, d_bit, b_out;

    // Full-subtractor bit cell on the operand LSBs.
    assign x_bit = a_sr_q[0];
    assign y_bit = b_sr_q[0];
    assign b_in  = borrow_q;
    assign d_bit = x_bit ^ y_bit ^ b_in;
    assign b_out = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & b_in);

    assign sub.ready_in   = (state_q == IDLE);
    assign sub.busy       = (state_q == SHIFT);
    assign sub.out_valid  = (state_q == HOLD);
    assign sub.diff       = diff_q;
    assign sub.borrow_out = borrow_out_q;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            diff_q       <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            diff_q       <= diff_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and datapath update; start outside IDLE is simply ignored.
    always_comb begin
        state_d      = state_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        diff_d       = diff_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (sub.start) begin
                    a_sr_d   = sub.a;
                    b_sr_d   = sub.b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                diff_d   = {d_bit, diff_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                borrow_d = b_out;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    borrow_out_d = b_out;
                    cnt_d        = '0;
                    state_d      = HOLD;
                end
            end
            HOLD: begin
                if (sub.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_serial_half_subtractor_unit.sv
// Self-checking bench for serial_half_subtractor_unit: directed cases plus
// random back-to-back operations, checked through a scoreboard queue.
module tb_serial_half_subtractor_unit;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         b;
    } result_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    result_t exp_q[$];

    serial_half_subtractor_unit_if #(.WIDTH(W)) sub ();

    serial_half_subtractor_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .sub (sub)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready_in"},  32'(sub.ready_in),   32'd1);
        chk({name, "_busy"},      32'(sub.busy),       32'd0);
        chk({name, "_out_valid"}, 32'(sub.out_valid),  32'd0);
        chk({name, "_diff"},      32'(sub.diff),       32'd0);
        chk({name, "_borrow"},    32'(sub.borrow_out), 32'd0);
    endtask

    // Monitor: every completed output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && sub.out_valid && sub.out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got diff=0x%0h borrow=%0b with nothing pending",
                         sub.diff, sub.borrow_out);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                chk("sb_diff",   32'(sub.diff),       32'(e.d));
                chk("sb_borrow", 32'(sub.borrow_out), 32'(e.b));
            end
        end
    end

    task automatic wait_ready();
        int w;
        w = 0;
        while (!sub.ready_in && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_in_timeout", 32'(sub.ready_in), 32'd1);
    endtask

    // One operation. hold = cycles of backpressure after out_valid rises;
    // inject = SHIFT cycle in which a stray start pulse is driven (0 = none).
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int hold, input int inject);
        logic [W-1:0] ed;
        logic         eb;
        result_t      r;
        ed = av - bv;
        eb = (av < bv);
        wait_ready();
        sub.out_ready = (hold == 0);
        sub.start = 1'b1;
        sub.a     = av;
        sub.b     = bv;
        r.d = ed;
        r.b = eb;
        exp_q.push_back(r);
        @(posedge clk); #1;
        sub.start = 1'b0;
        sub.a     = W'($urandom);
        sub.b     = W'($urandom);
        for (int i = 1; i <= W; i++) begin
            @(posedge clk); #1;
            sub.start = 1'b0;
            if (i == inject) begin
                sub.start = 1'b1;
                sub.a     = 8'hFF;
                sub.b     = 8'h00;
            end
            chk("latency_valid", 32'(sub.out_valid), 32'(i == W));
            chk("latency_busy",  32'(sub.busy),      32'(i < W));
        end
        sub.start = 1'b0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid",  32'(sub.out_valid),  32'd1);
            chk("hold_ready",  32'(sub.ready_in),   32'd0);
            chk("hold_diff",   32'(sub.diff),       32'(ed));
            chk("hold_borrow", 32'(sub.borrow_out), 32'(eb));
        end
        sub.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_valid", 32'(sub.out_valid), 32'd0);
        chk("post_hs_ready", 32'(sub.ready_in),  32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        sub.start     = 1'b0;
        sub.a         = '0;
        sub.b         = '0;
        sub.out_ready = 1'b1;
        #3;
        chk_reset_outputs("reset");
        #9;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after_reset_ready", 32'(sub.ready_in), 32'd1);

        do_op(8'h35, 8'h12, 0, 0);
        do_op(8'h00, 8'h01, 0, 0);
        do_op(8'hAA, 8'hAA, 0, 0);
        do_op(8'h00, 8'hFF, 0, 0);
        do_op(8'h80, 8'h7F, 5, 0);

        do_op(8'h10, 8'h01, 0, 3);
        for (int k = 0; k < 2 * W; k++) begin
            @(posedge clk); #1;
            chk("no_second_valid", 32'(sub.out_valid), 32'd0);
        end

        wait_ready();
        sub.start = 1'b1;
        sub.a     = 8'h5A;
        sub.b     = 8'h33;
        @(posedge clk); #1;
        sub.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        #3;
        rst = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk); #1;
            chk("no_valid_after_abort", 32'(sub.out_valid), 32'd0);
        end
        do_op(8'h01, 8'h02, 0, 0);

        for (int n = 0; n < 100; n++) begin
            do_op(W'($urandom), W'($urandom), 0, 0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
